ripple_count_capture: RTL and testbench

//   Consumes the free-running output of the JK-flop ripple counter, whose bits settle

---
 rtl/ripple_count_capture.sv | 115 +++++++++++
 tb/tb_ripple_count_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_capture.sv
// Brings a skewed, free-running ripple counter value into the clk domain, accepts it
// only once stable, accumulates wrapped deltas and offers snapshots via valid/ready.
module ripple_count_capture #(
  parameter int WIDTH  = 4,
  parameter int ACC_W  = 16,
  parameter int STABLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             en,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [ACC_W-1:0] snap_data,
  output logic [ACC_W-1:0] acc,
  output logic             wrap_pulse,
  output logic             acc_ovf
);

  localparam int HN   = (STABLE > 1) ? STABLE - 1 : 1;
  localparam int FILL = STABLE + 1;
  localparam int FW   = $clog2(FILL + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] hist [HN];
  logic [FW-1:0]    fill;
  logic             primed;
  logic             hist_eq;
  logic             accept;
  logic             wrap_now;
  logic [WIDTH-1:0] delta;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  // The reset contents of the sync/history chain are not real samples, so nothing
  // is accepted until the chain has been refilled from cnt_in since reset.
  assign primed = (fill == FW'(FILL));

  always_comb begin
    hist_eq = 1'b1;
    if (STABLE > 1) begin
      for (int i = 0; i < HN; i++) begin
        if (hist[i] != s2) hist_eq = 1'b0;
      end
    end
  end

  assign accept   = primed && hist_eq && ((state == INIT) || (s2 != last));
  assign delta    = s2 - last;
  assign wrap_now = (s2 < last);
  assign sum      = {1'b0, acc} + {{(ACC_W - WIDTH + 1){1'b0}}, delta};

  always_comb begin
    acc_next = acc;
    ovf_next = acc_ovf;
    if (clr) begin
      acc_next = '0;
      ovf_next = 1'b0;
    end else if (accept && (state == RUN) && en) begin
      acc_next = sum[ACC_W-1:0];
      ovf_next = acc_ovf | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      for (int i = 0; i < HN; i++) hist[i] <= '0;
      fill       <= '0;
      last       <= '0;
      state      <= INIT;
      acc        <= '0;
      acc_ovf    <= 1'b0;
      wrap_pulse <= 1'b0;
      snap_valid <= 1'b0;
      snap_data  <= '0;
    end else begin
      s1      <= cnt_in;
      s2      <= s1;
      hist[0] <= s2;
      for (int i = 1; i < HN; i++) hist[i] <= hist[i-1];
      if (!primed) fill <= fill + FW'(1);

      acc        <= acc_next;
      acc_ovf    <= ovf_next;
      wrap_pulse <= 1'b0;

      // clr wins over an accept in the same cycle and forces a fresh baseline
      if (clr) begin
        state <= INIT;
      end else if (accept) begin
        last  <= s2;
        state <= RUN;
        if (state == RUN) wrap_pulse <= wrap_now;
      end

      if (snap_valid && snap_ready) begin
        snap_valid <= 1'b0;
      end else if (!snap_valid && snap_req) begin
        snap_data  <= acc_next;
        snap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture (WIDTH=4, ACC_W=8, STABLE=2): a transaction
// model predicts acc/wrap/ovf per accepted value and snapshot contents per request.
module tb_ripple_count_capture;

  localparam int WIDTH  = 4;
  localparam int ACC_W  = 8;
  localparam int STABLE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] cnt_in;
  logic             en;
  logic             clr;
  logic             snap_req;
  logic             snap_ready;
  logic             snap_valid;
  logic [ACC_W-1:0] snap_data;
  logic [ACC_W-1:0] acc;
  logic             wrap_pulse;
  logic             acc_ovf;

  ripple_count_capture #(.WIDTH(WIDTH), .ACC_W(ACC_W), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .en(en), .clr(clr),
    .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(snap_valid),
    .snap_data(snap_data), .acc(acc), .wrap_pulse(wrap_pulse), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int               edge_no;
    logic [ACC_W-1:0] acc;
    logic             wrap;
    logic             ovf;
  } exp_t;

  exp_t             exp_q[$];
  logic [ACC_W-1:0] snap_q[$];

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               exp_wraps = 0;
  int               seen_wraps = 0;
  logic [ACC_W-1:0] m_acc;
  logic             m_ovf;
  logic             m_init;
  logic             m_snap_pend;
  logic [WIDTH-1:0] m_last;
  logic [WIDTH-1:0] cur;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Compare registered outputs just after each edge against scoreboard entries due then
  always @(posedge clk) begin
    exp_t it;
    cyc = cyc + 1;
    #1;
    if (wrap_pulse === 1'b1) seen_wraps++;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
      it = exp_q.pop_front();
      checkOutput("acc", 32'(acc), 32'(it.acc));
      checkOutput("wrap_pulse", 32'(wrap_pulse), 32'(it.wrap));
      checkOutput("acc_ovf", 32'(acc_ovf), 32'(it.ovf));
    end
  end

  task automatic pushExp(input int edge_no, input logic [ACC_W-1:0] a, input logic w, input logic o);
    exp_t it;
    it.edge_no = edge_no;
    it.acc     = a;
    it.wrap    = w;
    it.ovf     = o;
    exp_q.push_back(it);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] val, input int hold);
    int         k;
    logic [8:0] s9;
    logic [3:0] d;
    logic       w;
    @(negedge clk);
    cnt_in = val;
    k = cyc;
    if (hold >= STABLE) begin
      if (m_init) begin
        m_last = val;
        m_init = 1'b0;
        pushExp(k + 4, m_acc, 1'b0, m_ovf);
      end else if (val != m_last) begin
        d = val - m_last;
        w = (val < m_last);
        pushExp(k + 3, m_acc, 1'b0, m_ovf);
        if (en) begin
          s9    = {1'b0, m_acc} + {5'd0, d};
          m_ovf = m_ovf | s9[8];
          m_acc = s9[7:0];
        end
        pushExp(k + 4, m_acc, w, m_ovf);
        if (w) exp_wraps++;
        m_last = val;
      end
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setEn(input logic v);
    idle(3);
    en = v;
  endtask

  task automatic doClear(input logic with_snap);
    idle(4);
    @(negedge clk);
    clr = 1'b1;
    snap_req = with_snap;
    m_acc = '0;
    m_ovf = 1'b0;
    m_init = 1'b0;
    m_last = cnt_in;
    pushExp(cyc + 1, '0, 1'b0, 1'b0);
    if (with_snap && !m_snap_pend) begin
      snap_q.push_back('0);
      m_snap_pend = 1'b1;
    end
    @(negedge clk);
    clr = 1'b0;
    snap_req = 1'b0;
  endtask

  task automatic requestSnap();
    idle(4);
    @(negedge clk);
    snap_req = 1'b1;
    if (!m_snap_pend) begin
      snap_q.push_back(m_acc);
      m_snap_pend = 1'b1;
    end
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  task automatic holdSnap(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("snap_valid_hold", 32'(snap_valid), 32'd1);
      if (snap_q.size() > 0) checkOutput("snap_data_hold", 32'(snap_data), 32'(snap_q[0]));
    end
  endtask

  task automatic releaseSnap();
    logic [ACC_W-1:0] e;
    @(negedge clk);
    checkOutput("snap_valid_pre", 32'(snap_valid), 32'd1);
    checkOutput("snap_q_size", 32'(snap_q.size()), 32'd1);
    if (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      checkOutput("snap_data", 32'(snap_data), 32'(e));
    end
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    m_snap_pend = 1'b0;
    checkOutput("snap_valid_post", 32'(snap_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cnt_in = 4'd5; en = 1'b1; clr = 1'b0;
    snap_req = 1'b0; snap_ready = 1'b0;
    m_acc = '0; m_ovf = 1'b0; m_init = 1'b1; m_snap_pend = 1'b0; m_last = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_acc", 32'(acc), 32'd0);
    checkOutput("rst_wrap", 32'(wrap_pulse), 32'd0);
    checkOutput("rst_ovf", 32'(acc_ovf), 32'd0);
    checkOutput("rst_snap_valid", 32'(snap_valid), 32'd0);
    checkOutput("rst_snap_data", 32'(snap_data), 32'd0);
    rst = 1'b0;

    $display("[TB] baseline, latency, wrap, glitch");
    applyStimulus(4'd5, 10);
    applyStimulus(4'd9, 5);
    applyStimulus(4'd14, 5);
    applyStimulus(4'd2, 5);
    applyStimulus(4'd6, 5);
    applyStimulus(4'd3, 1);
    applyStimulus(4'd7, 5);
    applyStimulus(4'd8, 2);
    applyStimulus(4'd11, 2);

    $display("[TB] en=0 window");
    setEn(1'b0);
    applyStimulus(4'd12, 4);
    applyStimulus(4'd1, 4);
    setEn(1'b1);
    applyStimulus(4'd3, 4);

    $display("[TB] accumulator overflow and clr");
    doClear(1'b0);
    cur = 4'd3;
    for (int i = 0; i < 16; i++) begin
      cur = cur + 4'd15;
      applyStimulus(cur, 3);
    end
    cur = cur + 4'd10;
    applyStimulus(cur, 3);
    cur = cur + 4'd9;
    applyStimulus(cur, 3);
    cur = cur + 4'd1;
    applyStimulus(cur, 3);
    doClear(1'b0);
    cur = cur + 4'd5;
    applyStimulus(cur, 4);

    $display("[TB] snapshot handshake");
    doClear(1'b0);
    cur = cur + 4'd15; applyStimulus(cur, 3);
    cur = cur + 4'd15; applyStimulus(cur, 3);
    cur = cur + 4'd10; applyStimulus(cur, 3);
    requestSnap();
    holdSnap(5);
    cur = cur + 4'd5; applyStimulus(cur, 3);
    requestSnap();
    holdSnap(2);
    releaseSnap();
    requestSnap();
    releaseSnap();
    doClear(1'b1);
    releaseSnap();

    $display("[TB] reset mid-operation");
    cur = cur + 4'd7; applyStimulus(cur, 3);
    requestSnap();
    idle(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_acc", 32'(acc), 32'd0);
    checkOutput("midrst_snap_valid", 32'(snap_valid), 32'd0);
    checkOutput("midrst_ovf", 32'(acc_ovf), 32'd0);
    exp_q.delete();
    snap_q.delete();
    m_acc = '0; m_ovf = 1'b0; m_init = 1'b1; m_snap_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(cur, 6);
    cur = cur + 4'd6; applyStimulus(cur, 4);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    idle(2);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("wrap_count", 32'(seen_wraps), 32'(exp_wraps));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
